bomb_field_ctrl: RTL and testbench
==================================

// Module: bomb_field_ctrl
// PURPOSE
//  Parametrised bomb/flame engine for the playfield: owns every cell's bomb fuse and flame timer.
//  Accepts put requests from N players, enforces per-player capacity, and casts wall-blocked blasts.
//  Bombs caught in a blast chain-detonate. Feeds the renderer (bomb/flame masks) and game logic (hit tests).
//  Sits between the player controllers and the tile/VGA renderer.
// PARAMETERS
//  GRID_W      16  playfield columns
//  GRID_H      16  playfield rows; CELLS=GRID_W*GRID_H, COR_W=$clog2(CELLS)
//  N_PLAYERS   2   number of bomb-placing players
//  MAX_BOMBS   4   simultaneous live bombs per player; CNT_W=$clog2(MAX_BOMBS+1)
//  MAX_RANGE   4   longest blast arm in cells; RNG_W=$clog2(MAX_RANGE+1)
//  FUSE_TICKS  60  ticks from placement to detonation
//  FLAME_TICKS 18  ticks a cell stays lit after the last blast reached it
// PORTS
//  clk        in   1               system clock
//  reset      in   1               asynchronous, active-high
//  tick       in   1               frame-rate enable; all game state advances only on tick=1
//  put        in   N_PLAYERS       place request per player, sampled only when tick=1
//  put_cor    in   N_PLAYERS*COR_W target cell per player (row*GRID_W+col), player p at [p*COR_W+:COR_W]
//  put_range  in   N_PLAYERS*RNG_W blast range per player for the bomb being placed
//  wall_grid  in   CELLS           1 = solid wall; blocks placement and flame
//  bomb_grid  out  CELLS           1 = live bomb in cell
//  flame_grid out  CELLS           1 = cell currently lit
//  bomb_active out N_PLAYERS*CNT_W live bomb count per player
//  put_ack    out  N_PLAYERS       1-cycle pulse: request accepted
//  put_nack   out  N_PLAYERS       1-cycle pulse: request rejected
//  detonate   out  1               1-cycle pulse: at least one bomb detonated this tick
// BEHAVIOUR
//  - Reset (any time, incl. mid-fuse): all cells EMPTY, all counters 0, all outputs 0. Async assert.
//  - All outputs are registered. Each output reflects the tick that caused it on the following cycle.
//  - Per-cell state: EMPTY/BOMB/FLAME, owner, range, a timer, and chain_pend.
//    * BOMB timer = fuse. FLAME timer = remaining lit ticks.
//  - Put validity, with cor=put_cor[p], requires all of:
//    * put[p]=1 and tick=1;
//    * cor<CELLS;
//    * wall_grid[cor]=0;
//    * cell EMPTY this tick and not lit by this tick's blast;
//    * bomb_active[p]<MAX_BOMBS.
//    Invalid -> put_nack[p]. Valid -> put_ack[p], cell=BOMB, fuse=FUSE_TICKS, owner=p,
//    range=clamp(put_range,1,MAX_RANGE) (0 treated as 1), bomb_active[p]+1.
//  - Same-cell collision in one tick: lowest player index wins; the others get nack.
//  - Fuse: decrements each tick. Detonation set D = bombs with fuse==1 or chain_pend=1.
//    A bomb placed at tick t0 detonates at tick t0+FUSE_TICKS.
//  - Blast per bomb in D, centre plus 4 arms of its range:
//    * an arm stops before the first wall cell (wall is not lit);
//    * an arm stops at the grid edge, with no row/column wrap;
//    * arms pass through bombs and flames.
//  - Lit cells: EMPTY/FLAME -> FLAME with timer=FLAME_TICKS (re-lighting restarts the timer).
//    Bomb cells not in D -> chain_pend=1, detonating on the next tick (one tick per chain hop).
//  - Detonated cell -> FLAME, timer=FLAME_TICKS. Owner's bomb_active decrements. detonate pulses.
//    Multiple detonations of one owner in a tick subtract their full count.
//  - FLAME timer decrements each tick; at 1 -> EMPTY.
//  - Same-tick ordering:
//    1. fuse/flame update;
//    2. blast mask from D;
//    3. put acceptance against the post-blast map.
//  - tick=0: state, counts and grids hold; ack/nack/detonate are 0.
// STRUCTURE
//  - bomb_pkg: cell_state_e (EMPTY, BOMB, FLAME).
//  - bomb_pkg: cell_t struct (state, owner, range, timer, chain_pend).
//  - bomb_pkg: cor2row/cor2col functions.
//  - bomb_blast_ray: combinational sub-module.
//    * inputs: detonation mask, per-cell range, wall_grid;
//    * output: CELLS lit mask;
//    * one generate loop per direction x distance 1..MAX_RANGE.
//  - Top: cell register array, put arbiter, per-player counters.
// TESTING (defaults, tick=1 every cycle unless noted)
//  1. P0 put cor=34 (r2,c2) range 2
//     -> ack; bomb_grid[34] set for 60 ticks; bomb_active[0] 1->0;
//     -> flame on {34,32,33,35,36,2,18,50,66} for 18 ticks, then clear.
//  2. wall_grid[35]=1, P0 bomb at 34 range 3
//     -> flame {34,33,32,18,2,50,66,82}; 35 and 36 never lit.
//  3. Chain: A at 34 (t0), B at 36 (t0+10), range 2
//     -> A detonates t0+60, B detonates t0+61 (not t0+70); detonate pulses twice.
//  4. Capacity: P0 puts 5 distinct cells in 5 ticks -> 4 acks, 5th nack; bomb_active[0]=4.
//  5. P0 and P1 put cor=100 same tick -> P0 ack, P1 nack.
//     Later put on a lit cell or wall cell -> nack.
//  6. Assert reset mid-fuse with tick=0 between ticks
//     -> all grids, counts and pulses 0 immediately; fresh put after release acks normally.

Source files
------------

// File: rtl/bomb_pkg.sv
// Shared types for the bomb/flame engine: per-cell state record and grid coordinate helpers.
// Field widths are sized for grids up to 16 players, blast range 15 and timers up to 255 ticks.
package bomb_pkg;

    localparam int OWNER_W = 4;
    localparam int RANGE_W = 4;
    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BOMB  = 2'd1,
        FLAME = 2'd2
    } cell_state_e;

    typedef struct packed {
        cell_state_e          state;
        logic [OWNER_W-1:0]   owner;
        logic [RANGE_W-1:0]   blastRange;
        logic [TIMER_W-1:0]   timer;
        logic                 chainPend;
    } cell_t;

    function automatic int cor2row(input int cor, input int gridW);
        return cor / gridW;
    endfunction

    function automatic int cor2col(input int cor, input int gridW);
        return cor % gridW;
    endfunction

endpackage

// File: rtl/bomb_blast_ray.sv
// Combinational blast caster: marks every cell reached by a detonating bomb's centre or arms.
// Each target cell looks back along the four directions for a detonating source within range.
module bomb_blast_ray
    import bomb_pkg::*;
#(
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 16,
    parameter int MAX_RANGE = 4,
    localparam int CELLS    = GRID_W * GRID_H
) (
    input  logic [CELLS-1:0]               detMask_i,
    input  logic [CELLS-1:0][RANGE_W-1:0]  rangeGrid_i,
    input  logic [CELLS-1:0]               wallGrid_i,
    output logic [CELLS-1:0]               litMask_o
);

    for (genvar c = 0; c < CELLS; c++) begin : gCell
        localparam int ROW = cor2row(c, GRID_W);
        localparam int COL = cor2col(c, GRID_W);

        logic [4*MAX_RANGE-1:0] hit;

        for (genvar dir = 0; dir < 4; dir++) begin : gDir
            localparam int DR = (dir == 0) ? -1 : (dir == 1) ? 1 : 0;
            localparam int DC = (dir == 2) ? -1 : (dir == 3) ? 1 : 0;

            for (genvar d = 1; d <= MAX_RANGE; d++) begin : gDist
                localparam int SR = ROW - d * DR;
                localparam int SC = COL - d * DC;

                if (SR < 0 || SR >= GRID_H || SC < 0 || SC >= GRID_W) begin : gOff
                    assign hit[dir*MAX_RANGE + d - 1] = 1'b0;
                end else begin : gOn
                    localparam int SRC = SR * GRID_W + SC;
                    logic [d-1:0] pathWall;

                    // Every cell from the target back to the source's neighbour must be open.
                    for (genvar k = 0; k < d; k++) begin : gPath
                        assign pathWall[k] = wallGrid_i[(ROW - k * DR) * GRID_W + (COL - k * DC)];
                    end

                    assign hit[dir*MAX_RANGE + d - 1] = detMask_i[SRC]
                                                     && (rangeGrid_i[SRC] >= RANGE_W'(d))
                                                     && !(|pathWall);
                end
            end
        end

        assign litMask_o[c] = detMask_i[c] | (|hit);
    end

endmodule

// File: rtl/bomb_field_ctrl.sv
// Bomb/flame engine for the playfield: per-cell fuse and flame timers, chained blasts,
// per-player bomb capacity and put arbitration. All outputs come straight from registers.
module bomb_field_ctrl
    import bomb_pkg::*;
#(
    parameter int GRID_W      = 16,
    parameter int GRID_H      = 16,
    parameter int N_PLAYERS   = 2,
    parameter int MAX_BOMBS   = 4,
    parameter int MAX_RANGE   = 4,
    parameter int FUSE_TICKS  = 60,
    parameter int FLAME_TICKS = 18,
    localparam int CELLS      = GRID_W * GRID_H,
    localparam int COR_W      = $clog2(CELLS),
    localparam int CNT_W      = $clog2(MAX_BOMBS + 1),
    localparam int RNG_W      = $clog2(MAX_RANGE + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic [N_PLAYERS-1:0]        put,
    input  logic [N_PLAYERS*COR_W-1:0]  put_cor,
    input  logic [N_PLAYERS*RNG_W-1:0]  put_range,
    input  logic [CELLS-1:0]            wall_grid,
    output logic [CELLS-1:0]            bomb_grid,
    output logic [CELLS-1:0]            flame_grid,
    output logic [N_PLAYERS*CNT_W-1:0]  bomb_active,
    output logic [N_PLAYERS-1:0]        put_ack,
    output logic [N_PLAYERS-1:0]        put_nack,
    output logic                        detonate
);

    localparam cell_t EMPTY_CELL = '{state: EMPTY, owner: '0, blastRange: '0,
                                     timer: '0, chainPend: 1'b0};
    localparam cell_t LIT_CELL   = '{state: FLAME, owner: '0, blastRange: '0,
                                     timer: TIMER_W'(FLAME_TICKS), chainPend: 1'b0};

    cell_t                 cells_q [CELLS];
    cell_t                 cells_d [CELLS];
    logic [CNT_W-1:0]      bombActive_q [N_PLAYERS];
    logic [CNT_W-1:0]      bombActive_d [N_PLAYERS];
    logic [CELLS-1:0]      bombGrid_q, bombGrid_d;
    logic [CELLS-1:0]      flameGrid_q, flameGrid_d;
    logic [N_PLAYERS-1:0]  putAck_q, putAck_d;
    logic [N_PLAYERS-1:0]  putNack_q, putNack_d;
    logic                  detonate_q, detonate_d;

    logic [CELLS-1:0]              detMask;
    logic [CELLS-1:0]              litMask;
    logic [CELLS-1:0][RANGE_W-1:0] rangeGrid;

    logic [CNT_W-1:0]  detCount  [N_PLAYERS];
    logic [CNT_W-1:0]  liveCount [N_PLAYERS];
    logic [COR_W-1:0]  putCor;
    logic [RNG_W-1:0]  putRng;
    logic              putOk;

    function automatic logic [RANGE_W-1:0] clampRange(input logic [RNG_W-1:0] r);
        if (r == '0) begin
            return RANGE_W'(1);
        end
        if (int'(r) > MAX_RANGE) begin
            return RANGE_W'(MAX_RANGE);
        end
        return RANGE_W'(r);
    endfunction

    // A bomb goes off when its fuse is on its last tick or a previous blast reached it.
    always_comb begin
        detMask   = '0;
        rangeGrid = '0;
        for (int c = 0; c < CELLS; c++) begin
            rangeGrid[c] = cells_q[c].blastRange;
            if (cells_q[c].state == BOMB
                && (cells_q[c].timer <= TIMER_W'(1) || cells_q[c].chainPend)) begin
                detMask[c] = 1'b1;
            end
        end
    end

    bomb_blast_ray #(
        .GRID_W    (GRID_W),
        .GRID_H    (GRID_H),
        .MAX_RANGE (MAX_RANGE)
    ) uBlastRay (
        .detMask_i   (detMask),
        .rangeGrid_i (rangeGrid),
        .wallGrid_i  (wall_grid),
        .litMask_o   (litMask)
    );

    always_comb begin
        cells_d    = cells_q;
        putAck_d   = '0;
        putNack_d  = '0;
        detonate_d = 1'b0;
        putCor     = '0;
        putRng     = '0;
        putOk      = 1'b0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            detCount[p]     = '0;
            liveCount[p]    = bombActive_q[p];
            bombActive_d[p] = bombActive_q[p];
        end

        if (tick) begin
            detonate_d = |detMask;

            // Timers advance first, then the blast overlays the updated map.
            for (int c = 0; c < CELLS; c++) begin
                if (detMask[c]) begin
                    for (int p = 0; p < N_PLAYERS; p++) begin
                        if (cells_q[c].owner == OWNER_W'(p)) begin
                            detCount[p] = detCount[p] + 1'b1;
                        end
                    end
                    cells_d[c] = LIT_CELL;
                end else begin
                    if (cells_q[c].state == BOMB) begin
                        cells_d[c].timer = cells_q[c].timer - 1'b1;
                    end else if (cells_q[c].state == FLAME) begin
                        if (cells_q[c].timer <= TIMER_W'(1)) begin
                            cells_d[c] = EMPTY_CELL;
                        end else begin
                            cells_d[c].timer = cells_q[c].timer - 1'b1;
                        end
                    end
                    if (litMask[c]) begin
                        if (cells_d[c].state == BOMB) begin
                            cells_d[c].chainPend = 1'b1;
                        end else begin
                            cells_d[c] = LIT_CELL;
                        end
                    end
                end
            end

            for (int p = 0; p < N_PLAYERS; p++) begin
                liveCount[p] = bombActive_q[p] - detCount[p];
            end

            // Players are served in index order, so an earlier winner makes the cell non-empty.
            for (int p = 0; p < N_PLAYERS; p++) begin
                if (put[p]) begin
                    putCor = put_cor[p*COR_W +: COR_W];
                    putRng = put_range[p*RNG_W +: RNG_W];
                    putOk  = (int'(putCor) < CELLS) && (liveCount[p] < CNT_W'(MAX_BOMBS));
                    if (putOk) begin
                        putOk = !wall_grid[putCor] && (cells_d[putCor].state == EMPTY);
                    end
                    if (putOk) begin
                        putAck_d[p]     = 1'b1;
                        cells_d[putCor] = '{state: BOMB, owner: OWNER_W'(p),
                                            blastRange: clampRange(putRng),
                                            timer: TIMER_W'(FUSE_TICKS), chainPend: 1'b0};
                        liveCount[p]    = liveCount[p] + 1'b1;
                    end else begin
                        putNack_d[p] = 1'b1;
                    end
                end
            end

            for (int p = 0; p < N_PLAYERS; p++) begin
                bombActive_d[p] = liveCount[p];
            end
        end

        for (int c = 0; c < CELLS; c++) begin
            bombGrid_d[c]  = (cells_d[c].state == BOMB);
            flameGrid_d[c] = (cells_d[c].state == FLAME);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CELLS; c++) begin
                cells_q[c] <= EMPTY_CELL;
            end
            for (int p = 0; p < N_PLAYERS; p++) begin
                bombActive_q[p] <= '0;
            end
            bombGrid_q  <= '0;
            flameGrid_q <= '0;
            putAck_q    <= '0;
            putNack_q   <= '0;
            detonate_q  <= 1'b0;
        end else begin
            cells_q      <= cells_d;
            bombActive_q <= bombActive_d;
            bombGrid_q   <= bombGrid_d;
            flameGrid_q  <= flameGrid_d;
            putAck_q     <= putAck_d;
            putNack_q    <= putNack_d;
            detonate_q   <= detonate_d;
        end
    end

    assign bomb_grid  = bombGrid_q;
    assign flame_grid = flameGrid_q;
    assign put_ack    = putAck_q;
    assign put_nack   = putNack_q;
    assign detonate   = detonate_q;

    for (genvar p = 0; p < N_PLAYERS; p++) begin : gActive
        assign bomb_active[p*CNT_W +: CNT_W] = bombActive_q[p];
    end

endmodule

// File: tb/tb_bomb_field_ctrl.sv
// Scoreboard bench for bomb_field_ctrl: a cell-list reference model predicts every tick's outputs,
// a negedge monitor compares them, and directed scenarios add spot checks on key moments.
module tb_bomb_field_ctrl;

    localparam int GRID_W = 16;
    localparam int GRID_H = 16;
    localparam int CELLS  = 256;
    localparam int NP     = 2;
    localparam int COR_W  = 8;
    localparam int RNG_W  = 3;
    localparam int CNT_W  = 3;
    localparam int MAXB   = 4;
    localparam int MAXR   = 4;
    localparam int FUSE   = 60;
    localparam int FLAMET = 18;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   tick = 1'b0;
    logic [NP-1:0]          put = '0;
    logic [NP*COR_W-1:0]    put_cor = '0;
    logic [NP*RNG_W-1:0]    put_range = '0;
    logic [CELLS-1:0]       wall_grid = '0;
    logic [CELLS-1:0]       bomb_grid;
    logic [CELLS-1:0]       flame_grid;
    logic [NP*CNT_W-1:0]    bomb_active;
    logic [NP-1:0]          put_ack;
    logic [NP-1:0]          put_nack;
    logic                   detonate;

    bomb_field_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .put         (put),
        .put_cor     (put_cor),
        .put_range   (put_range),
        .wall_grid   (wall_grid),
        .bomb_grid   (bomb_grid),
        .flame_grid  (flame_grid),
        .bomb_active (bomb_active),
        .put_ack     (put_ack),
        .put_nack    (put_nack),
        .detonate    (detonate)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NP-1:0]       ack;
        logic [NP-1:0]       nack;
        logic                det;
        logic [CELLS-1:0]    bombs;
        logic [CELLS-1:0]    flames;
        logic [NP*CNT_W-1:0] active;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   compared = 0;
    int   mismatched = 0;

    // Reference model: 0 empty, 1 bomb, 2 flame.
    int kind[CELLS];
    int fuseLeft[CELLS];
    int flameLeft[CELLS];
    int owner[CELLS];
    int reach[CELLS];
    bit pend[CELLS];
    int live[NP];
    int stepR[4] = '{-1, 1, 0, 0};
    int stepC[4] = '{0, 0, -1, 1};

    task automatic checkOutput(input string name, input logic [CELLS-1:0] got,
                               input logic [CELLS-1:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < CELLS; c++) begin
            kind[c] = 0; fuseLeft[c] = 0; flameLeft[c] = 0;
            owner[c] = 0; reach[c] = 0; pend[c] = 1'b0;
        end
        for (int p = 0; p < NP; p++) live[p] = 0;
    endtask

    task automatic modelTick(input bit tk, input bit [NP-1:0] pv, input int c0, input int r0,
                             input int c1, input int r1, output exp_t e);
        bit isDet[CELLS];
        bit lit[CELLS];
        int cors[NP];
        int rngs[NP];
        int r, col, nr, nc, cor, rg;
        cors[0] = c0; cors[1] = c1;
        rngs[0] = r0; rngs[1] = r1;
        e.ack = '0; e.nack = '0; e.det = 1'b0;
        if (tk) begin
            for (int c = 0; c < CELLS; c++) begin
                isDet[c] = (kind[c] == 1) && (fuseLeft[c] == 1 || pend[c]);
                lit[c]   = 1'b0;
            end
            for (int c = 0; c < CELLS; c++) begin
                if (!isDet[c]) begin
                    if (kind[c] == 1) fuseLeft[c]--;
                    else if (kind[c] == 2) begin
                        if (flameLeft[c] == 1) kind[c] = 0;
                        else flameLeft[c]--;
                    end
                end
            end
            for (int c = 0; c < CELLS; c++) begin
                if (isDet[c]) begin
                    lit[c] = 1'b1;
                    r = c / GRID_W;
                    col = c % GRID_W;
                    for (int dir = 0; dir < 4; dir++) begin
                        for (int d = 1; d <= reach[c]; d++) begin
                            nr = r + stepR[dir] * d;
                            nc = col + stepC[dir] * d;
                            if (nr < 0 || nr >= GRID_H || nc < 0 || nc >= GRID_W) break;
                            if (wall_grid[nr*GRID_W + nc]) break;
                            lit[nr*GRID_W + nc] = 1'b1;
                        end
                    end
                end
            end
            for (int c = 0; c < CELLS; c++) begin
                if (isDet[c]) begin
                    kind[c] = 2; flameLeft[c] = FLAMET; pend[c] = 1'b0;
                    live[owner[c]]--;
                    e.det = 1'b1;
                end else if (lit[c]) begin
                    if (kind[c] == 1) pend[c] = 1'b1;
                    else begin kind[c] = 2; flameLeft[c] = FLAMET; end
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (pv[p]) begin
                    cor = cors[p];
                    if (cor < CELLS && !wall_grid[cor] && kind[cor] == 0 && live[p] < MAXB) begin
                        rg = (rngs[p] == 0) ? 1 : (rngs[p] > MAXR) ? MAXR : rngs[p];
                        kind[cor] = 1; fuseLeft[cor] = FUSE; owner[cor] = p;
                        reach[cor] = rg; pend[cor] = 1'b0;
                        live[p]++;
                        e.ack[p] = 1'b1;
                    end else begin
                        e.nack[p] = 1'b1;
                    end
                end
            end
        end
        for (int c = 0; c < CELLS; c++) begin
            e.bombs[c]  = (kind[c] == 1);
            e.flames[c] = (kind[c] == 2);
        end
        for (int p = 0; p < NP; p++) e.active[p*CNT_W +: CNT_W] = CNT_W'(live[p]);
    endtask

    task automatic applyStimulus(input bit tk, input bit [NP-1:0] pv, input int c0, input int r0,
                                 input int c1, input int r1);
        exp_t e;
        tick      = tk;
        put       = pv;
        put_cor   = {COR_W'(c1), COR_W'(c0)};
        put_range = {RNG_W'(r1), RNG_W'(r0)};
        modelTick(tk, pv, c0, r0, c1, r1, e);
        @(posedge clk);
        expQ.push_back(e);
        #1;
        tick = 1'b0;
        put  = '0;
    endtask

    task automatic idleTicks(input int n);
        repeat (n) applyStimulus(1'b1, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_bomb_grid"}, bomb_grid, '0);
        checkOutput({tag, "_flame_grid"}, flame_grid, '0);
        checkOutput({tag, "_bomb_active"}, CELLS'(bomb_active), '0);
        checkOutput({tag, "_put_ack"}, CELLS'(put_ack), '0);
        checkOutput({tag, "_put_nack"}, CELLS'(put_nack), '0);
        checkOutput({tag, "_detonate"}, CELLS'(detonate), '0);
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        tick  = 1'b0;
        put   = '0;
        #1;
        checkAllZero("midrst");
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: each tick's registered response is compared half a cycle after it appears.
    always @(negedge clk) begin
        if (!reset && expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkOutput("put_ack", CELLS'(put_ack), CELLS'(monExp.ack));
            checkOutput("put_nack", CELLS'(put_nack), CELLS'(monExp.nack));
            checkOutput("detonate", CELLS'(detonate), CELLS'(monExp.det));
            checkOutput("bomb_grid", bomb_grid, monExp.bombs);
            checkOutput("flame_grid", flame_grid, monExp.flames);
            checkOutput("bomb_active", CELLS'(bomb_active), CELLS'(monExp.active));
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [CELLS-1:0] mask1, mask2, only36;
        int list1[9] = '{34, 32, 33, 35, 36, 2, 18, 50, 66};
        int list2[8] = '{34, 33, 32, 18, 2, 50, 66, 82};
        bit tk;
        bit [NP-1:0] pv;

        mask1 = '0;
        mask2 = '0;
        only36 = '0;
        foreach (list1[i]) mask1[list1[i]] = 1'b1;
        foreach (list2[i]) mask2[list2[i]] = 1'b1;
        only36[36] = 1'b1;
        modelReset();

        #1 reset = 1'b1;
        #1 checkAllZero("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] scenario 1: single bomb, range 2");
        applyStimulus(1'b1, 2'b01, 34, 2, 0, 0);
        checkOutput("s1_ack", CELLS'(put_ack), CELLS'(1));
        idleTicks(59);
        checkOutput("s1_bomb_last_tick", CELLS'(bomb_grid[34]), CELLS'(1));
        idleTicks(1);
        checkOutput("s1_flame_shape", flame_grid, mask1);
        checkOutput("s1_active_zero", CELLS'(bomb_active), '0);
        idleTicks(17);
        checkOutput("s1_flame_hold", flame_grid, mask1);
        idleTicks(1);
        checkOutput("s1_flame_clear", flame_grid, '0);

        $display("[TB] scenario 2: wall blocks arm");
        wall_grid[35] = 1'b1;
        applyStimulus(1'b1, 2'b01, 34, 3, 0, 0);
        idleTicks(60);
        checkOutput("s2_flame_shape", flame_grid, mask2);
        idleTicks(20);
        wall_grid = '0;

        $display("[TB] scenario 3: chain detonation");
        applyStimulus(1'b1, 2'b01, 34, 2, 0, 0);
        idleTicks(9);
        applyStimulus(1'b1, 2'b01, 36, 2, 0, 0);
        idleTicks(50);
        checkOutput("s3_first_det", CELLS'(detonate), CELLS'(1));
        checkOutput("s3_chain_pending", bomb_grid, only36);
        idleTicks(1);
        checkOutput("s3_second_det", CELLS'(detonate), CELLS'(1));
        checkOutput("s3_all_gone", bomb_grid, '0);
        idleTicks(1);
        checkOutput("s3_det_idle", CELLS'(detonate), '0);
        idleTicks(20);

        $display("[TB] scenario 4: capacity");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b01, 100 + i, 1, 0, 0);
        checkOutput("s4_fifth_nack", CELLS'(put_nack), CELLS'(1));
        checkOutput("s4_active_four", CELLS'(bomb_active), CELLS'(4));
        idleTicks(90);

        $display("[TB] scenario 5: collision, lit cell, wall cell");
        wall_grid[120] = 1'b1;
        applyStimulus(1'b1, 2'b11, 100, 1, 100, 1);
        checkOutput("s5_ack", CELLS'(put_ack), CELLS'(1));
        checkOutput("s5_nack", CELLS'(put_nack), CELLS'(2));
        idleTicks(60);
        applyStimulus(1'b1, 2'b11, 100, 1, 120, 1);
        checkOutput("s5_lit_wall_nack", CELLS'(put_nack), CELLS'(3));
        idleTicks(20);
        wall_grid = '0;

        $display("[TB] scenario 6: reset mid-fuse");
        applyStimulus(1'b1, 2'b01, 50, 2, 0, 0);
        idleTicks(20);
        repeat (3) applyStimulus(1'b0, 2'b00, 0, 0, 0, 0);
        doReset();
        applyStimulus(1'b1, 2'b01, 50, 2, 0, 0);
        checkOutput("s6_fresh_ack", CELLS'(put_ack), CELLS'(1));
        checkOutput("s6_fresh_active", CELLS'(bomb_active), CELLS'(1));

        $display("[TB] random phase");
        doReset();
        for (int c = 0; c < 96; c++) wall_grid[c] = ($urandom_range(0, 99) < 8);
        for (int i = 0; i < 1500; i++) begin
            tk = ($urandom_range(0, 99) < 85);
            pv[0] = ($urandom_range(0, 99) < 30);
            pv[1] = ($urandom_range(0, 99) < 30);
            applyStimulus(tk, pv, int'($urandom_range(0, 95)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 95)), int'($urandom_range(0, 7)));
        end
        idleTicks(100);

        @(negedge clk);
        #1;
        checkOutput("queue_drained", CELLS'(expQ.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
